// File: rtl/kalman_channel_scheduler.sv
// Round-robin front end that shares one kalman_filter datapath among N_CH sensor channels.
// Each accepted measurement is held on filt_meas, its result is captured once, and it is returned tagged with its channel.
module kalman_channel_scheduler #(
    parameter int DATA_WIDTH = 16,
    parameter int N_CH       = 4,
    parameter int CH_W       = 2,
    parameter int FILT_LAT   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CH-1:0]            req_valid,
    input  logic [N_CH*DATA_WIDTH-1:0] req_data,
    output logic [N_CH-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]      filt_meas,
    output logic                       filt_start,
    input  logic [DATA_WIDTH-1:0]      filt_result,
    output logic                       out_valid,
    output logic [CH_W-1:0]            out_ch,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int CNT_W = $clog2(FILT_LAT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gch;
    logic [CNT_W-1:0]  cnt;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    logic              accept;
    logic              capture;
    logic              release_done;
    logic              cnt_last;

    // Walk backwards so the channel closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req_valid[(int'(rr_ptr) + i) % N_CH]) begin
                grant_vld = 1'b1;
                grant_ch  = CH_W'((int'(rr_ptr) + i) % N_CH);
            end
        end
    end

    assign cnt_last = (cnt == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = WAIT;
            WAIT:    if (cnt_last)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept       = (state == IDLE) && grant_vld;
        capture      = (state == WAIT) && cnt_last;
        release_done = (state == DONE) && out_ready;
        busy         = (state != IDLE);
        req_ready    = accept ? (N_CH'(1) << grant_ch) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr     <= '0;
            gch        <= '0;
            cnt        <= '0;
            filt_meas  <= '0;
            filt_start <= 1'b0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
        end else begin
            filt_start <= accept;
            if (accept) begin
                filt_meas <= req_data[grant_ch*DATA_WIDTH +: DATA_WIDTH];
                gch       <= grant_ch;
                cnt       <= CNT_W'(FILT_LAT);
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            // filt_result is sampled exactly once per accepted measurement.
            if (capture) begin
                out_data  <= filt_result;
                out_ch    <= gch;
                out_valid <= 1'b1;
            end
            if (release_done) begin
                out_valid <= 1'b0;
                rr_ptr    <= (gch == CH_W'(N_CH - 1)) ? '0 : gch + CH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_kalman_channel_scheduler.sv
// Bench for kalman_channel_scheduler: vector table, corner sequences, random run against a transaction model.
module tb_kalman_channel_scheduler;

    localparam int LAT_A = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  rv_a, rdy_a, rv_b, rdy_b;
    logic [63:0] rd_a, rd_b;
    logic [15:0] fm_a, fr_a, od_a, fm_b, fr_b, od_b;
    logic        fs_a, ov_a, ordy_a, busy_a, fs_b, ov_b, ordy_b, busy_b;
    logic [1:0]  och_a, och_b;
    logic [15:0] pipe1_b, pipe2_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kalman_channel_scheduler #(.DATA_WIDTH(16), .N_CH(4), .CH_W(2), .FILT_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(rv_a), .req_data(rd_a), .req_ready(rdy_a),
        .filt_meas(fm_a), .filt_start(fs_a), .filt_result(fr_a), .out_valid(ov_a),
        .out_ch(och_a), .out_data(od_a), .out_ready(ordy_a), .busy(busy_a));

    kalman_channel_scheduler #(.DATA_WIDTH(16), .N_CH(4), .CH_W(2), .FILT_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(rv_b), .req_data(rd_b), .req_ready(rdy_b),
        .filt_meas(fm_b), .filt_start(fs_b), .filt_result(fr_b), .out_valid(ov_b),
        .out_ch(och_b), .out_data(od_b), .out_ready(ordy_b), .busy(busy_b));

    // Filter stubs: identity with latency 1, and (meas+1) with latency 3.
    assign fr_a = fm_a;
    always_ff @(posedge clk) begin
        pipe1_b <= fm_b + 16'd1;
        pipe2_b <= pipe1_b;
    end
    assign fr_b = pipe2_b;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int grant(input logic [3:0] v, input int rr);
        for (int i = 0; i < 4; i++)
            if (v[(rr + i) % 4]) return (rr + i) % 4;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        rv_a = '0; rd_a = '0; ordy_a = 1'b1;
        rv_b = '0; rd_b = '0; ordy_b = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  rv;
        logic [15:0] d;
        int          dch;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_ch;
        logic [15:0] e_dat;
        logic        e_busy;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{4'b0000, 16'h0000, 0, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b0};
        tbl[1]  = '{4'b0100, 16'h1234, 2, 1'b1, 4'b0100, 1'b0, 2'd0, 16'h0000, 1'b0};
        tbl[2]  = '{4'b0000, 16'h0000, 0, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1};
        tbl[3]  = '{4'b0000, 16'h0000, 0, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h1234, 1'b1};
        tbl[4]  = '{4'b0001, 16'h0000, 0, 1'b1, 4'b0000, 1'b1, 2'd2, 16'h1234, 1'b1};
        tbl[5]  = '{4'b0001, 16'hABCD, 0, 1'b1, 4'b0001, 1'b0, 2'd0, 16'h0000, 1'b0};
        tbl[6]  = '{4'b0000, 16'h0000, 0, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1};
        tbl[7]  = '{4'b0000, 16'h0000, 0, 1'b1, 4'b0000, 1'b1, 2'd0, 16'hABCD, 1'b1};
        tbl[8]  = '{4'b1001, 16'h5555, 3, 1'b1, 4'b1000, 1'b0, 2'd0, 16'h0000, 1'b0};
        tbl[9]  = '{4'b0000, 16'h0000, 0, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000, 1'b1};
        tbl[10] = '{4'b0000, 16'h0000, 0, 1'b1, 4'b0000, 1'b1, 2'd3, 16'h5555, 1'b1};
        tbl[11] = '{4'b1001, 16'h0000, 0, 1'b1, 4'b0001, 1'b0, 2'd0, 16'h0000, 1'b0};

        // Reset state
        do_reset();
        #1;
        chk("reset_out_valid", ov_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_out_data", od_a, 0);
        chk("reset_filt_meas", fm_a, 0);
        chk("reset_filt_start", fs_a, 0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rv_a = tbl[i].rv;
            rd_a = '0;
            rd_a[tbl[i].dch*16 +: 16] = tbl[i].d;
            ordy_a = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_req_ready", i), rdy_a, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busy", i), busy_a, tbl[i].e_busy);
            chk($sformatf("tbl%0d_out_valid", i), ov_a, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_ch", i), och_a, tbl[i].e_ch);
                chk($sformatf("tbl%0d_out_data", i), od_a, tbl[i].e_dat);
            end
        end

        // Reset mid-WAIT discards the sample and returns rr_ptr to 0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rv_a = (k == 0) ? 4'b0010 : (k == 3) ? 4'b0100 : 4'b0000;
            #1;
        end
        chk("rst_pre_ready_ch2", rdy_a, 4'b0100);
        @(negedge clk);
        rv_a = '0;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_out_valid", ov_a, 0);
        chk("rst_mid_filt_start", fs_a, 0);
        chk("rst_mid_filt_meas", fm_a, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("rst_after_out_valid", ov_a, 0);
        end
        @(negedge clk);
        rv_a = 4'b0101;
        #1;
        chk("rst_next_grant_ch0", rdy_a, 4'b0001);

        // All channels requesting, out_ready held: 0,1,2,3,0 every 3 cycles
        do_reset();
        for (int c = 0; c < 4; c++) rd_a[c*16 +: 16] = 16'h1000 * 16'(c + 1) + 16'(c);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            rv_a = 4'b1111;
            ordy_a = 1'b1;
            #1;
            chk("rr_req_ready", rdy_a, (k % 3 == 0) ? 4'(1 << ((k / 3) % 4)) : 4'b0000);
            chk("rr_out_valid", ov_a, (k % 3 == 2));
            if (k % 3 == 2) begin
                chk("rr_out_ch", och_a, (k / 3) % 4);
                chk("rr_out_data", od_a, 16'h1000 * 16'(((k / 3) % 4) + 1) + 16'((k / 3) % 4));
            end
        end

        // Backpressure for 10 cycles, then release
        do_reset();
        @(negedge clk);
        rv_a = 4'b0010; rd_a[31:16] = 16'hBEEF; ordy_a = 1'b0;
        #1;
        chk("bp_accept", rdy_a, 4'b0010);
        @(negedge clk);
        rv_a = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("bp_out_valid", ov_a, 1);
            chk("bp_out_ch", och_a, 1);
            chk("bp_out_data", od_a, 16'hBEEF);
            chk("bp_req_ready", rdy_a, 0);
            chk("bp_busy", busy_a, 1);
        end
        @(negedge clk);
        ordy_a = 1'b1;
        #1;
        chk("bp_release_valid", ov_a, 1);
        @(negedge clk);
        #1;
        chk("bp_idle_busy", busy_a, 0);
        chk("bp_idle_valid", ov_a, 0);
        chk("bp_idle_next_grant", rdy_a, 4'b0100);

        // Wrap-around between ch3 and ch0 starting from rr_ptr=3
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rv_a = (k == 0) ? 4'b0100 : 4'b0000;
            #1;
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            rv_a = 4'b1001;
            #1;
            if (k % 3 == 0) chk("wrap_grant", rdy_a, ((k / 3) % 2 == 0) ? 4'b1000 : 4'b0001);
        end

        // FILT_LAT=3 instance with (meas+1) stub
        do_reset();
        @(negedge clk);
        rv_b = 4'b0001; rd_b[15:0] = 16'h00FF;
        #1;
        chk("lat3_accept", rdy_b, 4'b0001);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rv_b = '0;
            #1;
            chk("lat3_out_valid_low", ov_b, 0);
            chk("lat3_busy", busy_b, 1);
            if (k == 1) begin
                chk("lat3_filt_start", fs_b, 1);
                chk("lat3_filt_meas", fm_b, 16'h00FF);
            end
        end
        @(negedge clk);
        #1;
        chk("lat3_out_valid", ov_b, 1);
        chk("lat3_out_data", od_b, 16'h0100);
        chk("lat3_out_ch", och_b, 0);

        // Random traffic against a transaction-level model
        begin
            bit          m_idle = 1'b1;
            int          m_rr = 0, m_ch = 0, m_acc = 0, g;
            logic [15:0] m_data = '0;
            logic        e_ov;
            logic [3:0]  e_rdy;
            do_reset();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                @(negedge clk);
                rv_a = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
                rd_a = {$urandom, $urandom};
                ordy_a = ($urandom_range(0, 2) != 0);
                #1;
                g = grant(rv_a, m_rr);
                e_ov = !m_idle && (cyc >= m_acc + LAT_A + 1);
                e_rdy = (m_idle && g >= 0) ? 4'(1 << g) : 4'b0000;
                chk("rnd_req_ready", rdy_a, e_rdy);
                chk("rnd_busy", busy_a, !m_idle);
                chk("rnd_out_valid", ov_a, e_ov);
                chk("rnd_filt_start", fs_a, !m_idle && (cyc == m_acc + 1));
                if (e_ov) begin
                    chk("rnd_out_ch", och_a, m_ch);
                    chk("rnd_out_data", od_a, m_data);
                end
                if (m_idle && g >= 0) begin
                    m_idle = 1'b0;
                    m_ch = g;
                    m_data = rd_a[g*16 +: 16];
                    m_acc = cyc;
                end else if (e_ov && ordy_a) begin
                    m_idle = 1'b1;
                    m_rr = (m_ch + 1) % 4;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
